// File: rtl/reset_request_ctrl.sv
// Reset request sequencer: turns one-cycle reset requests into a counted ASSERT level
// for the reset generator, waits out the recovery window, then pulses DONE.
module reset_request_ctrl #(
    parameter int CNT_W       = 8,
    parameter int RECOVER     = 4,
    parameter int DEF_HOLD    = 16,
    parameter bit INIT_ASSERT = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ,
    input  logic [CNT_W-1:0] HOLD_CYCLES,
    input  logic             FORCE,
    output logic             REQ_ACK,
    output logic             ASSERT_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

    localparam int               REC_W    = (RECOVER > 0) ? $clog2(RECOVER + 1) : 1;
    localparam logic [REC_W-1:0] REC_LOAD = REC_W'(RECOVER);
    localparam logic [CNT_W-1:0] DEF_LOAD = (DEF_HOLD > 0) ? CNT_W'(DEF_HOLD) : CNT_W'(1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [REC_W-1:0] rec_cnt, rec_nxt;
    logic             pending, pend_nxt;
    logic             ack_nxt;
    logic [CNT_W-1:0] h_eff;

    // A zero hold request still produces a one-cycle assertion.
    assign h_eff = (HOLD_CYCLES == '0) ? ONE : HOLD_CYCLES;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        hold_nxt  = hold_cnt;
        rec_nxt   = rec_cnt;
        pend_nxt  = pending;
        ack_nxt   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (REQ) begin
                    state_nxt = ST_ASSERT;
                    hold_nxt  = h_eff;
                    ack_nxt   = 1'b1;
                end else if (FORCE) begin
                    state_nxt = ST_ASSERT;
                    hold_nxt  = ONE;
                end
            end

            ST_ASSERT: begin
                if (REQ) begin
                    hold_nxt = h_eff;
                    ack_nxt  = 1'b1;
                end else if (!FORCE) begin
                    if (hold_cnt <= ONE) begin
                        if (RECOVER == 0) begin
                            state_nxt = ST_FINISH;
                        end else begin
                            state_nxt = ST_RECOVER;
                            rec_nxt   = REC_LOAD;
                        end
                    end else begin
                        hold_nxt = hold_cnt - ONE;
                    end
                end
            end

            ST_RECOVER: begin
                if (FORCE) begin
                    state_nxt = ST_ASSERT;
                    pend_nxt  = 1'b0;
                    hold_nxt  = REQ ? h_eff : ONE;
                    ack_nxt   = REQ;
                end else begin
                    // hold_cnt is idle here, so it doubles as storage for the pending hold length.
                    if (REQ) begin
                        pend_nxt = 1'b1;
                        hold_nxt = h_eff;
                        ack_nxt  = 1'b1;
                    end
                    if (rec_cnt <= REC_W'(1)) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        rec_nxt = rec_cnt - REC_W'(1);
                    end
                end
            end

            default: begin
                pend_nxt = 1'b0;
                if (REQ) begin
                    state_nxt = ST_ASSERT;
                    hold_nxt  = h_eff;
                    ack_nxt   = 1'b1;
                end else if (pending) begin
                    state_nxt = ST_ASSERT;
                end else if (FORCE) begin
                    state_nxt = ST_ASSERT;
                    hold_nxt  = ONE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!RST_N) begin
            state      <= INIT_ASSERT ? ST_ASSERT : ST_IDLE;
            hold_cnt   <= INIT_ASSERT ? DEF_LOAD : '0;
            rec_cnt    <= '0;
            pending    <= 1'b0;
            REQ_ACK    <= 1'b0;
            DONE       <= 1'b0;
            ASSERT_OUT <= INIT_ASSERT;
            BUSY       <= INIT_ASSERT;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            rec_cnt    <= rec_nxt;
            pending    <= pend_nxt;
            REQ_ACK    <= ack_nxt;
            ASSERT_OUT <= (state_nxt == ST_ASSERT);
            BUSY       <= (state_nxt != ST_IDLE);
            // DONE is visible during the FINISH cycle unless a merged request is waiting.
            DONE       <= (state_nxt == ST_FINISH) && !pend_nxt;
        end
    end

endmodule

// File: tb/tb_reset_request_ctrl.sv
// Scoreboard bench for reset_request_ctrl: stimulus queues expected event cycles,
// a negedge monitor pops and compares them as the DUT produces each event.
module tb_reset_request_ctrl;

    localparam int CNT_W = 8;

    localparam int EV_ACK   = 0;
    localparam int EV_ARISE = 1;
    localparam int EV_AFALL = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_BRISE = 4;
    localparam int EV_BFALL = 5;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             REQ;
    logic [CNT_W-1:0] HOLD_CYCLES;
    logic             FORCE;
    logic             REQ_ACK;
    logic             ASSERT_OUT;
    logic             BUSY;
    logic             DONE;

    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    bit   mon_on    = 1'b0;
    logic prev_ast  = 1'b0;
    logic prev_busy = 1'b0;

    int q_ack[$];
    int q_arise[$];
    int q_afall[$];
    int q_done[$];
    int q_brise[$];
    int q_bfall[$];

    reset_request_ctrl #(
        .CNT_W(CNT_W),
        .RECOVER(4),
        .DEF_HOLD(16),
        .INIT_ASSERT(1'b1)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .REQ(REQ),
        .HOLD_CYCLES(HOLD_CYCLES),
        .FORCE(FORCE),
        .REQ_ACK(REQ_ACK),
        .ASSERT_OUT(ASSERT_OUT),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int stamp);
        case (kind)
            EV_ACK:   q_ack.push_back(stamp);
            EV_ARISE: q_arise.push_back(stamp);
            EV_AFALL: q_afall.push_back(stamp);
            EV_DONE:  q_done.push_back(stamp);
            EV_BRISE: q_brise.push_back(stamp);
            default:  q_bfall.push_back(stamp);
        endcase
    endtask

    task automatic observe(input int kind, input string name);
        int exp_c;
        bit have;
        have  = 1'b0;
        exp_c = 0;
        case (kind)
            EV_ACK:   if (q_ack.size() > 0)   begin exp_c = q_ack.pop_front();   have = 1'b1; end
            EV_ARISE: if (q_arise.size() > 0) begin exp_c = q_arise.pop_front(); have = 1'b1; end
            EV_AFALL: if (q_afall.size() > 0) begin exp_c = q_afall.pop_front(); have = 1'b1; end
            EV_DONE:  if (q_done.size() > 0)  begin exp_c = q_done.pop_front();  have = 1'b1; end
            EV_BRISE: if (q_brise.size() > 0) begin exp_c = q_brise.pop_front(); have = 1'b1; end
            default:  if (q_bfall.size() > 0) begin exp_c = q_bfall.pop_front(); have = 1'b1; end
        endcase
        if (have) begin
            check(name, cyc, exp_c);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected event at cycle %0d, none expected", name, cyc);
        end
    endtask

    // Monitor: each output event is stamped with the index of the edge that produced it.
    always @(negedge CLK) begin
        if (mon_on) begin
            if (REQ_ACK === 1'b1) observe(EV_ACK, "req_ack");
            if (ASSERT_OUT === 1'b1 && prev_ast !== 1'b1) observe(EV_ARISE, "assert_rise");
            if (ASSERT_OUT === 1'b0 && prev_ast === 1'b1) observe(EV_AFALL, "assert_fall");
            if (DONE === 1'b1) observe(EV_DONE, "done");
            if (BUSY === 1'b1 && prev_busy !== 1'b1) observe(EV_BRISE, "busy_rise");
            if (BUSY === 1'b0 && prev_busy === 1'b1) observe(EV_BFALL, "busy_fall");
        end
        prev_ast  = ASSERT_OUT;
        prev_busy = BUSY;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic req_pulse(input logic [CNT_W-1:0] h);
        REQ         = 1'b1;
        HOLD_CYCLES = h;
        tick();
        REQ = 1'b0;
    endtask

    initial begin
        int b;
        int waited;

        RST_N       = 1'b0;
        REQ         = 1'b0;
        FORCE       = 1'b0;
        HOLD_CYCLES = '0;

        // 1: power-on assertion, last reset edge is 3 -> fall 3+16, DONE 4 later
        repeat (3) tick();
        mon_on = 1'b1;
        expect_ev(EV_AFALL, 19);
        expect_ev(EV_DONE, 23);
        expect_ev(EV_BFALL, 24);
        @(negedge CLK);
        check("rst_assert_out", ASSERT_OUT, 1);
        check("rst_busy", BUSY, 1);
        check("rst_req_ack", REQ_ACK, 0);
        check("rst_done", DONE, 0);
        RST_N = 1'b1;

        // 2: plain request, H=3
        goto(30);
        b = cyc;
        expect_ev(EV_ACK, b + 1);
        expect_ev(EV_ARISE, b + 1);
        expect_ev(EV_BRISE, b + 1);
        expect_ev(EV_AFALL, b + 4);
        expect_ev(EV_DONE, b + 8);
        expect_ev(EV_BFALL, b + 9);
        req_pulse(8'd3);

        // 3a: HOLD_CYCLES=0 behaves as 1
        goto(45);
        b = cyc;
        expect_ev(EV_ACK, b + 1);
        expect_ev(EV_ARISE, b + 1);
        expect_ev(EV_BRISE, b + 1);
        expect_ev(EV_AFALL, b + 2);
        expect_ev(EV_DONE, b + 6);
        expect_ev(EV_BFALL, b + 7);
        req_pulse(8'd0);

        // 3b: H=2 then extension with H=5 on the next edge
        goto(60);
        b = cyc;
        expect_ev(EV_ACK, b + 1);
        expect_ev(EV_ACK, b + 2);
        expect_ev(EV_ARISE, b + 1);
        expect_ev(EV_BRISE, b + 1);
        expect_ev(EV_AFALL, b + 7);
        expect_ev(EV_DONE, b + 11);
        expect_ev(EV_BFALL, b + 12);
        req_pulse(8'd2);
        req_pulse(8'd5);

        // 4: request during RECOVER merges; one DONE only
        goto(80);
        b = cyc;
        expect_ev(EV_ACK, b + 1);
        expect_ev(EV_ACK, b + 5);
        expect_ev(EV_ARISE, b + 1);
        expect_ev(EV_ARISE, b + 8);
        expect_ev(EV_AFALL, b + 3);
        expect_ev(EV_AFALL, b + 11);
        expect_ev(EV_BRISE, b + 1);
        expect_ev(EV_DONE, b + 15);
        expect_ev(EV_BFALL, b + 16);
        req_pulse(8'd2);
        repeat (3) tick();
        req_pulse(8'd3);

        // 5: FORCE for 20 cycles in ASSERT, then again in RECOVER
        goto(100);
        b = cyc;
        expect_ev(EV_ACK, b + 1);
        expect_ev(EV_ARISE, b + 1);
        expect_ev(EV_ARISE, b + 27);
        expect_ev(EV_AFALL, b + 25);
        expect_ev(EV_AFALL, b + 47);
        expect_ev(EV_BRISE, b + 1);
        expect_ev(EV_DONE, b + 51);
        expect_ev(EV_BFALL, b + 52);
        req_pulse(8'd4);
        tick();
        FORCE = 1'b1;
        repeat (20) tick();
        FORCE = 1'b0;
        repeat (4) tick();
        FORCE = 1'b1;
        repeat (20) tick();
        FORCE = 1'b0;

        // 6: reset mid-ASSERT (with REQ high) restarts the power-on hold
        goto(160);
        b = cyc;
        expect_ev(EV_ACK, b + 1);
        expect_ev(EV_ARISE, b + 1);
        expect_ev(EV_BRISE, b + 1);
        expect_ev(EV_AFALL, b + 19);
        expect_ev(EV_DONE, b + 23);
        expect_ev(EV_BFALL, b + 24);
        req_pulse(8'd6);
        tick();
        RST_N = 1'b0;
        REQ   = 1'b1;
        tick();
        RST_N = 1'b0;
        REQ   = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        check("midrst_assert_out", ASSERT_OUT, 1);
        check("midrst_req_ack", REQ_ACK, 0);
        check("midrst_busy", BUSY, 1);
        goto(b + 30);

        check("sb_ack_left", q_ack.size(), 0);
        check("sb_arise_left", q_arise.size(), 0);
        check("sb_afall_left", q_afall.size(), 0);
        check("sb_done_left", q_done.size(), 0);
        check("sb_brise_left", q_brise.size(), 0);
        check("sb_bfall_left", q_bfall.size(), 0);

        // Soak: random REQ/FORCE with output invariants
        mon_on = 1'b0;
        for (int i = 0; i < 400; i++) begin
            REQ         = ($urandom_range(0, 9) == 0);
            FORCE       = ($urandom_range(0, 19) == 0);
            HOLD_CYCLES = CNT_W'($urandom_range(0, 7));
            @(negedge CLK);
            if (ASSERT_OUT === 1'b1) check("soak_busy_when_assert", BUSY, 1);
            if (DONE === 1'b1) check("soak_done_outputs", {BUSY, ASSERT_OUT}, 2'b10);
            tick();
        end
        REQ   = 1'b0;
        FORCE = 1'b0;
        waited = 0;
        while (BUSY !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        check("soak_drain_idle", BUSY, 0);
        check("soak_drain_assert", ASSERT_OUT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
